// File: rtl/vram_pkg.sv
// Shared definitions for the rectangle-fill engine: colour layout, VRAM word widths, fill FSM states.
package vram_pkg;

   localparam int VRAM_ADDR_W = 16;
   localparam int VRAM_DATA_W = 16;

   localparam int COLOR_W     = 12;
   localparam int COLOR_CH_W  = 4;
   localparam int COLOR_R_LSB = 0;
   localparam int COLOR_G_LSB = 4;
   localparam int COLOR_B_LSB = 8;

   typedef logic [COLOR_W-1:0]     color_t;
   typedef logic [VRAM_ADDR_W-1:0] vaddr_t;
   typedef logic [VRAM_DATA_W-1:0] vdata_t;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      FILL,
      DONE
   } fill_state_t;

   // VRAM words carry the 12-bit colour zero-extended into the upper nibble.
   function automatic vdata_t color_to_data(input color_t c);
      return {{(VRAM_DATA_W-COLOR_W){1'b0}}, c};
   endfunction

endpackage

// File: rtl/vram_rect_clip.sv
// Combinational clip of a fill command against the visible screen: empty flag, last
// column/row and the VRAM address of the first row.
module vram_rect_clip
   import vram_pkg::*;
#(
   parameter int H_RES  = 480,
   parameter int V_RES  = 136,
   parameter int STRIDE = 480
)(
   input  logic [9:0] x0_i,
   input  logic [9:0] y0_i,
   input  logic [9:0] w_i,
   input  logic [9:0] h_i,
   output logic       empty_o,
   output logic [9:0] x_last_o,
   output logic [9:0] y_last_o,
   output vaddr_t     row_base_o
);

   localparam logic [10:0] H_LIM = 11'(H_RES);
   localparam logic [10:0] V_LIM = 11'(V_RES);

   logic [10:0] x_end;
   logic [10:0] y_end;
   logic [10:0] x_lim;
   logic [10:0] y_lim;

   // 11 bits hold x0+w without overflow for any 10-bit operands.
   always_comb begin
      x_end = {1'b0, x0_i} + {1'b0, w_i};
      y_end = {1'b0, y0_i} + {1'b0, h_i};
      x_lim = (x_end < H_LIM) ? x_end : H_LIM;
      y_lim = (y_end < V_LIM) ? y_end : V_LIM;
   end

   assign empty_o    = (w_i == 10'd0) || (h_i == 10'd0) ||
                       ({1'b0, x0_i} >= H_LIM) || ({1'b0, y0_i} >= V_LIM);
   assign x_last_o   = 10'(x_lim - 11'd1);
   assign y_last_o   = 10'(y_lim - 11'd1);
   assign row_base_o = vaddr_t'(y0_i) * vaddr_t'(STRIDE);

endmodule

// File: rtl/vram_rect_fill.sv
// Rectangle-fill engine: one command in, clipped, then one VRAM pixel write per clock.
// Optional checkerboard colouring via VRAM_RECT_FILL_CHECKER_EN.
module vram_rect_fill
   import vram_pkg::*;
#(
   parameter int H_RES  = 480,
   parameter int V_RES  = 136,
   parameter int STRIDE = 480
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [9:0]  cmd_x0,
   input  logic [9:0]  cmd_y0,
   input  logic [9:0]  cmd_w,
   input  logic [9:0]  cmd_h,
   input  logic [11:0] cmd_color,
   input  logic [11:0] cmd_color2,
   input  logic        abort,
   output logic        busy,
   output logic        done,
   output logic [15:0] vram_write_addr,
   output logic [15:0] vram_write_data,
   output logic        vram_write_en
);

   localparam vaddr_t STRIDE_A = vaddr_t'(STRIDE);

   fill_state_t state_q;
   logic [9:0]  x0_q, y0_q, w_q, h_q;
   logic [9:0]  x_q, y_q, x_last_q, y_last_q;
   vaddr_t      row_base_q;
   color_t      color_q;
   vaddr_t      addr_q;
   vdata_t      data_q;
   logic        we_q;
   logic        done_q;

   logic        clip_empty;
   logic [9:0]  clip_x_last, clip_y_last;
   vaddr_t      clip_row_base;

   logic [9:0]  pix_x_d, pix_y_d;
   vaddr_t      row_base_d;
   vaddr_t      addr_d;
   vdata_t      data_d;
   logic        at_last;

`ifdef VRAM_RECT_FILL_CHECKER_EN
   color_t      color2_q;
`else
   logic        unused_color2;
   assign unused_color2 = ^cmd_color2;
`endif

   vram_rect_clip #(
      .H_RES  (H_RES),
      .V_RES  (V_RES),
      .STRIDE (STRIDE)
   ) u_clip (
      .x0_i       (x0_q),
      .y0_i       (y0_q),
      .w_i        (w_q),
      .h_i        (h_q),
      .empty_o    (clip_empty),
      .x_last_o   (clip_x_last),
      .y_last_o   (clip_y_last),
      .row_base_o (clip_row_base)
   );

   assign at_last = (x_q == x_last_q) && (y_q == y_last_q);

   // Next pixel to write: the rectangle origin out of SETUP, otherwise the raster successor.
   always_comb begin
      pix_x_d    = x_q + 10'd1;
      pix_y_d    = y_q;
      row_base_d = row_base_q;
      if (state_q == SETUP) begin
         pix_x_d    = x0_q;
         pix_y_d    = y0_q;
         row_base_d = clip_row_base;
      end else if (x_q == x_last_q) begin
         pix_x_d    = x0_q;
         pix_y_d    = y_q + 10'd1;
         row_base_d = row_base_q + STRIDE_A;
      end
      addr_d = row_base_d + vaddr_t'(pix_x_d);
`ifdef VRAM_RECT_FILL_CHECKER_EN
      data_d = color_to_data((pix_x_d[0] ^ pix_y_d[0]) ? color2_q : color_q);
`else
      data_d = color_to_data(color_q);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         x0_q       <= '0;
         y0_q       <= '0;
         w_q        <= '0;
         h_q        <= '0;
         x_q        <= '0;
         y_q        <= '0;
         x_last_q   <= '0;
         y_last_q   <= '0;
         row_base_q <= '0;
         color_q    <= '0;
`ifdef VRAM_RECT_FILL_CHECKER_EN
         color2_q   <= '0;
`endif
         addr_q     <= '0;
         data_q     <= '0;
         we_q       <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         we_q   <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  x0_q     <= cmd_x0;
                  y0_q     <= cmd_y0;
                  w_q      <= cmd_w;
                  h_q      <= cmd_h;
                  color_q  <= cmd_color;
`ifdef VRAM_RECT_FILL_CHECKER_EN
                  color2_q <= cmd_color2;
`endif
                  state_q  <= SETUP;
               end
            end
            SETUP: begin
               if (clip_empty || abort) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end else begin
                  state_q    <= FILL;
                  x_last_q   <= clip_x_last;
                  y_last_q   <= clip_y_last;
                  x_q        <= pix_x_d;
                  y_q        <= pix_y_d;
                  row_base_q <= row_base_d;
                  addr_q     <= addr_d;
                  data_q     <= data_d;
                  we_q       <= 1'b1;
               end
            end
            FILL: begin
               // The write currently on the port is the last one when aborting or at the corner.
               if (abort || at_last) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end else begin
                  x_q        <= pix_x_d;
                  y_q        <= pix_y_d;
                  row_base_q <= row_base_d;
                  addr_q     <= addr_d;
                  data_q     <= data_d;
                  we_q       <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign cmd_ready       = (state_q == IDLE) && !rst;
   assign busy            = (state_q != IDLE);
   assign done            = done_q;
   assign vram_write_addr = addr_q;
   assign vram_write_data = data_q;
   assign vram_write_en   = we_q;

endmodule

// File: tb/tb_vram_rect_fill.sv
// Directed bench for vram_rect_fill: a table of fill commands plus hand-written reset,
// abort and busy-time sequences.
module tb_vram_rect_fill;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [9:0]  cmd_x0 = '0, cmd_y0 = '0, cmd_w = '0, cmd_h = '0;
   logic [11:0] cmd_color = '0, cmd_color2 = '0;
   logic        abort = 1'b0;
   logic        busy, done;
   logic [15:0] vram_write_addr, vram_write_data;
   logic        vram_write_en;

   vram_rect_fill dut (
      .clk             (clk),
      .rst             (rst),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_x0          (cmd_x0),
      .cmd_y0          (cmd_y0),
      .cmd_w           (cmd_w),
      .cmd_h           (cmd_h),
      .cmd_color       (cmd_color),
      .cmd_color2      (cmd_color2),
      .abort           (abort),
      .busy            (busy),
      .done            (done),
      .vram_write_addr (vram_write_addr),
      .vram_write_data (vram_write_data),
      .vram_write_en   (vram_write_en)
   );

   always #5 clk = ~clk;

   typedef struct {
      int x0, y0, w, h, color, color2, abort_k;
      int exp_n, exp_wc, exp_first;
   } vec_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   vec_t        vecs[$];
   logic [15:0] got_data[$];

   task automatic check(input string name, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   function automatic int exp_data(input vec_t v, input int i);
`ifdef VRAM_RECT_FILL_CHECKER_EN
      int x, y;
      x = v.x0 + i % v.exp_wc;
      y = v.y0 + i / v.exp_wc;
      return ((x ^ y) & 1) != 0 ? v.color2 : v.color;
`else
      return v.color + 0 * i;
`endif
   endfunction

   task automatic drive_cmd(input int x0, input int y0, input int w, input int h,
                            input int c, input int c2);
      cmd_x0     = 10'(x0);
      cmd_y0     = 10'(y0);
      cmd_w      = 10'(w);
      cmd_h      = 10'(h);
      cmd_color  = 12'(c);
      cmd_color2 = 12'(c2);
      cmd_valid  = 1'b1;
   endtask

   // Called at a negedge with the engine idle. Cycle k counts negedges after the accept edge.
   task automatic run_vec(input int id, input vec_t v);
      int nw, done_k, ndone, bad_a, bad_d, bad_t, we_at_done, rdy_after;
      nw = 0; done_k = -1; ndone = 0; bad_a = 0; bad_d = 0; bad_t = 0;
      we_at_done = 0; rdy_after = 0;
      got_data.delete();
      check($sformatf("v%0d_ready_before", id), int'(cmd_ready), 1);
      drive_cmd(v.x0, v.y0, v.w, v.h, v.color, v.color2);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int k = 1; k <= 3000; k++) begin
         abort = (k == v.abort_k);
         if (vram_write_en) begin
            if (k != nw + 2) bad_t++;
            if (vram_write_addr !== 16'(v.exp_first + (nw / v.exp_wc) * 480 + nw % v.exp_wc))
               bad_a++;
            if (vram_write_data !== 16'(exp_data(v, nw))) bad_d++;
            got_data.push_back(vram_write_data);
            nw++;
         end
         if (done) begin
            ndone++;
            if (done_k < 0) begin
               done_k     = k;
               we_at_done = int'(vram_write_en);
            end
         end
         if (done_k >= 0 && k == done_k + 1) begin
            rdy_after = int'(cmd_ready);
            break;
         end
         @(negedge clk);
      end
      abort = 1'b0;
      check($sformatf("v%0d_write_count", id), nw, v.exp_n);
      check($sformatf("v%0d_bad_addr_writes", id), bad_a, 0);
      check($sformatf("v%0d_bad_data_writes", id), bad_d, 0);
      check($sformatf("v%0d_mistimed_writes", id), bad_t, 0);
      check($sformatf("v%0d_done_pulses", id), ndone, 1);
      check($sformatf("v%0d_done_cycle", id), done_k, v.exp_n + 2);
      check($sformatf("v%0d_we_in_done_cycle", id), we_at_done, 0);
      check($sformatf("v%0d_ready_after_done", id), rdy_after, 1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          wk[$];
      int          wa[$];
      int          wd[$];
      int          dk[$];
      int          bad;
      int          cnt;
      int          ek[5];
      int          ea[5];
      int          ed[5];
      vec_t        cv;
      logic [15:0] chk_exp[4];

      //          x0   y0   w     h     col     col2    ab  n     wc   first
      vecs.push_back('{10,  2,   3,    2,    'h0F0, 'h00F, 0,  6,    3,   970});
      vecs.push_back('{478, 135, 5,    4,    'h123, 'h321, 0,  2,    2,   65278});
      vecs.push_back('{0,   0,   0,    5,    'hFFF, 'h000, 0,  0,    1,   0});
      vecs.push_back('{480, 0,   4,    4,    'hABC, 'h000, 0,  0,    1,   0});
      vecs.push_back('{0,   136, 1,    1,    'hABC, 'h000, 0,  0,    1,   0});
      vecs.push_back('{7,   3,   4,    0,    'hABC, 'h000, 0,  0,    1,   0});
      vecs.push_back('{1023,1023,1023, 1023, 'hABC, 'h000, 0,  0,    1,   0});
      vecs.push_back('{479, 0,   1,    1,    'hFFF, 'h000, 0,  1,    1,   479});
      vecs.push_back('{5,   134, 2,    5,    'h5A5, 'hA5A, 0,  4,    2,   64325});
      vecs.push_back('{0,   0,   480,  1,    'h321, 'h123, 0,  480,  480, 0});
      vecs.push_back('{400, 100, 200,  100,  'h0C3, 'h3C0, 0,  2880, 80,  48400});
      vecs.push_back('{0,   0,   4,    4,    'h0F0, 'h00F, 4,  3,    4,   0});
      vecs.push_back('{0,   0,   2,    1,    'h111, 'h222, 3,  2,    2,   0});
      vecs.push_back('{20,  20,  4,    4,    'h333, 'h000, 1,  0,    1,   0});
      vecs.push_back('{1,   0,   2,    2,    'h00F, 'hF00, 0,  4,    2,   1});

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", int'(cmd_ready), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_we", int'(vram_write_en), 0);
      check("rst_addr", int'(vram_write_addr), 0);
      check("rst_data", int'(vram_write_data), 0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_cmd_ready", int'(cmd_ready), 1);

      // Abort while idle does nothing.
      abort = 1'b1;
      cnt = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         cnt += int'(done) + int'(busy) + int'(vram_write_en);
      end
      abort = 1'b0;
      check("idle_abort_activity", cnt, 0);

      foreach (vecs[i]) run_vec(i, vecs[i]);

`ifdef VRAM_RECT_FILL_CHECKER_EN
      cv = '{1, 0, 2, 2, 'h00F, 'hF00, 0, 4, 2, 1};
      run_vec(99, cv);
      chk_exp[0] = 16'h0F00; chk_exp[1] = 16'h000F;
      chk_exp[2] = 16'h000F; chk_exp[3] = 16'h0F00;
      bad = (got_data.size() == 4) ? 0 : 1;
      for (int i = 0; i < 4 && i < got_data.size(); i++)
         if (got_data[i] !== chk_exp[i]) bad++;
      check("checker_data_sequence", bad, 0);
`endif

      // Reset during the second write of a 4x4 fill.
      drive_cmd(0, 0, 4, 4, 'h777, 'h000);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      check("rstfill_w1_en", int'(vram_write_en), 1);
      check("rstfill_w1_addr", int'(vram_write_addr), 0);
      @(negedge clk);
      check("rstfill_w2_en", int'(vram_write_en), 1);
      check("rstfill_w2_addr", int'(vram_write_addr), 1);
      rst = 1'b1;
      @(negedge clk);
      check("rstfill_we_after", int'(vram_write_en), 0);
      check("rstfill_busy_after", int'(busy), 0);
      check("rstfill_done_after", int'(done), 0);
      check("rstfill_ready_in_rst", int'(cmd_ready), 0);
      check("rstfill_addr_after", int'(vram_write_addr), 0);
      rst = 1'b0;
      @(negedge clk);
      check("rstfill_ready_after", int'(cmd_ready), 1);
      cnt = 0;
      for (int k = 0; k < 6; k++) begin
         cnt += int'(vram_write_en) + int'(done);
         @(negedge clk);
      end
      check("rstfill_quiet", cnt, 0);

      // Command held valid across a fill is taken only once the engine is idle again.
      drive_cmd(0, 0, 3, 1, 'h0AA, 'h0AA);
      @(posedge clk);
      @(negedge clk);
      drive_cmd(100, 1, 2, 1, 'h055, 'h055);
      for (int k = 1; k <= 12; k++) begin
         if (vram_write_en) begin
            wk.push_back(k);
            wa.push_back(int'(vram_write_addr));
            wd.push_back(int'(vram_write_data));
         end
         if (done) dk.push_back(k);
         if (k == 7) cmd_valid = 1'b0;
         @(negedge clk);
      end
      ek = '{2, 3, 4, 8, 9};
      ea = '{0, 1, 2, 580, 581};
      ed = '{'h0AA, 'h0AA, 'h0AA, 'h055, 'h055};
      check("busy_write_count", wk.size(), 5);
      bad = 0;
      for (int i = 0; i < 5 && i < wk.size(); i++)
         if (wk[i] != ek[i] || wa[i] != ea[i] || wd[i] != ed[i]) bad++;
      check("busy_write_mismatches", bad, 0);
      check("busy_done_count", dk.size(), 2);
      check("busy_done_cycle_a", (dk.size() > 0) ? dk[0] : -1, 5);
      check("busy_done_cycle_b", (dk.size() > 1) ? dk[1] : -1, 10);
      check("busy_final_ready", int'(cmd_ready), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
